// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared defaults and channel state encoding for the button conditioner.
package scoreboard_pkg;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000;
    localparam int unsigned LONG_CYCLES_DEF     = 4096;
    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } chan_state_t;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-flop synchronizer, saturating stability counter and press/release FSM for one button.
module debounce_channel
    import scoreboard_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic button_i,
    output logic press_o,
    output logic level_o
);
    localparam logic [19:0] LIMIT = 20'(DEBOUNCE_CYCLES);

    logic [1:0]  sync;
    logic [19:0] cnt, cnt_nxt;
    logic        press_nxt, smp, done;
    chan_state_t state, state_nxt;

    assign smp     = sync[1];
    // The current sample is the one that would bring the run up to LIMIT.
    assign done    = ({1'b0, cnt} + 21'd1) >= {1'b0, LIMIT};
    assign level_o = (state == HELD) || (state == RELEASE_WAIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync    <= '0;
            state   <= IDLE;
            cnt     <= '0;
            press_o <= 1'b0;
        end else begin
            sync    <= {sync[0], button_i};
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            press_o <= press_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = smp ? PRESS_WAIT : IDLE;
                cnt_nxt   = smp ? 20'd1 : cnt;
            end
            PRESS_WAIT: begin
                state_nxt = !smp ? IDLE : (done ? HELD : PRESS_WAIT);
                cnt_nxt   = done ? LIMIT : cnt + 20'd1;
                press_nxt = smp && done;
            end
            HELD: begin
                state_nxt = smp ? HELD : RELEASE_WAIT;
                cnt_nxt   = smp ? cnt : 20'd1;
            end
            RELEASE_WAIT: begin
                state_nxt = smp ? HELD : (done ? IDLE : RELEASE_WAIT);
                cnt_nxt   = done ? LIMIT : cnt + 20'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: two independent debounced buttons with press pulses and levels;
// define BUTTON_LONGPRESS_CLEAR_EN to add a clear_o pulse after both are held LONG_CYCLES.
module button_conditioner
    import scoreboard_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic p1_button_i,
    input  logic p2_button_i,
    output logic p1_press_o,
    output logic p2_press_o,
    output logic p1_level_o,
    output logic p2_level_o,
    output logic clear_o
);
    if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 32'hFFFFF) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (LONG_CYCLES == 0 || LONG_CYCLES > 32'hFFFFFF) begin : g_bad_long
        $error("LONG_CYCLES out of range");
    end

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_p1 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .button_i (p1_button_i),
        .press_o  (p1_press_o),
        .level_o  (p1_level_o)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_p2 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .button_i (p2_button_i),
        .press_o  (p2_press_o),
        .level_o  (p2_level_o)
    );

`ifdef BUTTON_LONGPRESS_CLEAR_EN
    localparam logic [23:0] LONG_LIMIT = 24'(LONG_CYCLES);
    logic [23:0] long_cnt;
    logic        both;

    assign both = p1_level_o && p2_level_o;

    // Counter parks at LONG_LIMIT so clear_o fires once per joint hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            long_cnt <= '0;
            clear_o  <= 1'b0;
        end else begin
            long_cnt <= !both ? 24'd0 : (long_cnt == LONG_LIMIT ? long_cnt : long_cnt + 24'd1);
            clear_o  <= both && (long_cnt == LONG_LIMIT - 24'd1);
        end
    end
`else
    assign clear_o = 1'b0;
`endif
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus checked every cycle against a run-length model.
module tb_button_conditioner;
    localparam int D = 4;
    localparam int L = 10;

    logic clk = 1'b0, rst = 1'b1, b1 = 1'b0, b2 = 1'b0;
    logic p1p, p2p, p1l, p2l, clr;

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .p1_button_i (b1),
        .p2_button_i (b2),
        .p1_press_o  (p1p),
        .p2_press_o  (p2p),
        .p1_level_o  (p1l),
        .p2_level_o  (p2l),
        .clear_o     (clr)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: raw input reaches the debouncer two edges late; the level flips
    // once D consecutive samples disagree with it; a rising flip is a press.
    logic [1:0] pipe [2];
    int  run [2];
    bit  lvl [2];
    bit  prs [2];
    int  m_cnt [2];
    int  m_edge [2];
    int  held, ecnt, m_clr_cnt, m_clr_edge;
    bit  e_clr, vld = 1'b0, both, s;
    logic [1:0] raw;

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                pipe[c] = 2'b00; run[c] = 0; lvl[c] = 0; prs[c] = 0;
                m_cnt[c] = 0; m_edge[c] = -1;
            end
            held = 0; ecnt = 0; e_clr = 0; m_clr_cnt = 0; m_clr_edge = -1;
            vld = 1'b1;
        end else begin
            raw  = {b2, b1};
            both = lvl[0] && lvl[1];
            for (int c = 0; c < 2; c++) begin
                s = pipe[c][1];
                pipe[c] = {pipe[c][0], raw[c]};
                prs[c] = 0;
                if (s != lvl[c]) begin
                    run[c]++;
                    if (run[c] == D) begin
                        lvl[c] = s;
                        run[c] = 0;
                        if (s) begin
                            prs[c] = 1;
                            m_cnt[c]++;
                            m_edge[c] = ecnt;
                        end
                    end
                end else begin
                    run[c] = 0;
                end
            end
            held = both ? held + 1 : 0;
`ifdef BUTTON_LONGPRESS_CLEAR_EN
            e_clr = (held == L);
`else
            e_clr = 0;
`endif
            if (e_clr) begin
                m_clr_cnt++;
                m_clr_edge = ecnt;
            end
            ecnt++;
        end
    end

    int d_cnt [2] = '{0, 0};
    int d_both = 0, d_clr = 0, d1_lvl = 0;

    always @(posedge clk) begin
        #1;
        if (vld) begin
            chk("p1_press", p1p, prs[0]);
            chk("p2_press", p2p, prs[1]);
            chk("p1_level", p1l, lvl[0]);
            chk("p2_level", p2l, lvl[1]);
            chk("clear", clr, e_clr);
            if (rst) begin
                d_cnt[0] = 0; d_cnt[1] = 0; d_both = 0; d_clr = 0; d1_lvl = 0;
            end else begin
                d_cnt[0] += int'(p1p);
                d_cnt[1] += int'(p2p);
                d_both   += int'(p1p && p2p);
                d_clr    += int'(clr);
                d1_lvl   += int'(p1l);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1; b1 = 1'b0; b2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("reset_p1_level", p1l, 0);
        chk("reset_clear", clr, 0);

        rst_pulse(); b1 = 1'b1; cyc(12);
        chk("A_model_p1_edge", m_edge[0], 5);
        chk("A_model_p1_cnt", m_cnt[0], 1);
        chk("A_dut_p1_cnt", d_cnt[0], 1);
        chk("A_dut_p2_cnt", d_cnt[1], 0);
        chk("A_dut_p1_level", p1l, 1);
        chk("A_dut_p2_level", p2l, 0);
        b1 = 1'b0; cyc(10);
        chk("A_release_level", p1l, 0);

        rst_pulse();
        for (int i = 0; i < 20; i++) begin
            b1 = (i % 2 == 0);
            cyc(1);
        end
        b1 = 1'b0; cyc(6);
        chk("B_model_p1_cnt", m_cnt[0], 0);
        chk("B_dut_p1_cnt", d_cnt[0], 0);
        chk("B_dut_level_seen", d1_lvl, 0);

        rst_pulse(); cyc(3); b1 = 1'b1; b2 = 1'b1; cyc(12);
        chk("C_model_p1_edge", m_edge[0], 8);
        chk("C_model_p2_edge", m_edge[1], 8);
        chk("C_dut_same_cycle", d_both, 1);
        b1 = 1'b0; b2 = 1'b0; cyc(8);

        rst_pulse();
        for (int i = 0; i < 50; i++) begin
            b2 = !(i == 20 || i == 21);
            cyc(1);
        end
        b2 = 1'b0; cyc(8);
        chk("D_model_p2_cnt", m_cnt[1], 1);
        chk("D_dut_p2_cnt", d_cnt[1], 1);

        rst_pulse(); b1 = 1'b1; cyc(3);
        chk("E_dut_pre_reset_cnt", d_cnt[0], 0);
        rst = 1'b1; cyc(1); rst = 1'b0; cyc(10);
        chk("E_model_p1_edge", m_edge[0], 5);
        chk("E_model_p1_cnt", m_cnt[0], 1);
        chk("E_dut_p1_cnt", d_cnt[0], 1);

        rst_pulse(); b1 = 1'b1; b2 = 1'b1; cyc(30);
`ifdef BUTTON_LONGPRESS_CLEAR_EN
        chk("F_model_clear_edge", m_clr_edge, 15);
        chk("F_model_clear_cnt", m_clr_cnt, 1);
        chk("F_dut_clear_cnt", d_clr, 1);
`else
        chk("F_model_clear_cnt", m_clr_cnt, 0);
        chk("F_dut_clear_cnt", d_clr, 0);
`endif
        b1 = 1'b0; b2 = 1'b0; cyc(8);

        rst_pulse();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 8 == 0) b1 = ~b1;
            if ($urandom % 8 == 0) b2 = ~b2;
            rst = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        rst = 1'b0; cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
